// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program store writer: streams words into prog[], validates each entry, releases the core
module prog_loader #(
  parameter int MAX_WORDS = 15,
  parameter int IMM_LIMIT = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] prog [0:MAX_WORDS-1],
  output logic [3:0]  pLength,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [2:0]  err_code,
  output logic [3:0]  err_addr
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CHECK, DONE, ERROR} state_t;

  localparam logic [3:0] LAST_IDX = 4'(MAX_WORDS - 1);

  state_t      state;
  logic [3:0]  wr_idx;
  logic [3:0]  chk_idx;
  logic [14:0] chk_word;
  logic [2:0]  chk_code;
  logic        accept;

  assign s_ready  = (state == IDLE || state == LOAD || state == DRAIN) && !reload;
  assign accept   = s_valid && s_ready;
  assign chk_word = prog[chk_idx][14:0];

  // MOV (bit 14 clear) is exempt from every rule; first matching rule wins.
  always_comb begin
    int imm;
    imm      = int'($signed(chk_word[10:0]));
    chk_code = 3'd0;
    if (chk_word[14]) begin
      if (chk_word[13:11] <= 3'b011)
        chk_code = 3'd2;
      else if (chk_word[13:11] == 3'b111 && chk_word[10:4] < 7'h7A)
        chk_code = 3'd2;
      else if (chk_word[13:11] == 3'b111 && chk_word[10:4] == 7'h7F && chk_word[3:0] < 4'hC)
        chk_code = 3'd2;
      else if (chk_word[13:11] == 3'b111 && chk_word[10:4] <= 7'h7E && chk_word[3:0] >= pLength)
        chk_code = 3'd3;
      else if ((chk_word[13:11] == 3'b100 || chk_word[13:11] == 3'b101) &&
               (imm > IMM_LIMIT || imm < -IMM_LIMIT))
        chk_code = 3'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < MAX_WORDS; i++) prog[i] <= 16'h7FFF;
      pLength   <= 4'd1;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= 3'd0;
      err_addr  <= 4'd0;
      wr_idx    <= 4'd0;
      chk_idx   <= 4'd0;
    end else if (reload) begin
      state     <= IDLE;
      for (int i = 0; i < MAX_WORDS; i++) prog[i] <= 16'h7FFF;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= 3'd0;
      err_addr  <= 4'd0;
      wr_idx    <= 4'd0;
      chk_idx   <= 4'd0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            prog[wr_idx] <= s_data;
            wr_idx       <= wr_idx + 4'd1;
            if (s_last) begin
              pLength <= wr_idx + 4'd1;
              chk_idx <= 4'd0;
              state   <= CHECK;
            end else if (wr_idx == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              state <= LOAD;
            end
          end
        end
        DRAIN: begin
          // Surplus words are swallowed so the sender can finish its packet.
          if (accept && s_last) begin
            state    <= ERROR;
            load_err <= 1'b1;
            err_code <= 3'd1;
            err_addr <= 4'd15;
          end
        end
        CHECK: begin
          if (chk_code != 3'd0) begin
            state    <= ERROR;
            load_err <= 1'b1;
            err_code <= chk_code;
            err_addr <= chk_idx;
          end else if (chk_idx == pLength - 4'd1) begin
            state     <= DONE;
            load_done <= 1'b1;
            core_rst  <= 1'b0;
          end else begin
            chk_idx <= chk_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
